// File: rtl/i2s_dac_tx_pkg.sv
// Purpose: shared widths, frame geometry and the I2S slot-to-bit mapping for the DAC transmitter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   IN_W, SAMPLE_W                  interpolator input width / DAC word width
//   FRAME_LEN, BCLK_DIV, SLOTS_PER_CH  frame geometry in clk cycles / bit periods
//   CNT_W, PH_W, SLOT_W             derived field widths of the frame counter {half, slot, phase}
//   sample_t                        one 24-bit DAC word
//   slot_bit()                      serial bit carried by a slot (I2S one-bit delay)
package audipus_pkg;

  localparam int IN_W         = 34;
  localparam int SAMPLE_W     = 24;
  localparam int FRAME_LEN    = 512;
  localparam int BCLK_DIV     = 8;
  localparam int SLOTS_PER_CH = 32;

  // Frame counter layout: [CNT_W-1] = channel half, [PH_W +: SLOT_W] = slot, [PH_W-1:0] = bit phase.
  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int PH_W   = $clog2(BCLK_DIV);
  localparam int SLOT_W = $clog2(SLOTS_PER_CH);

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Slot 0 is the I2S one-bit delay after the word-select edge; slots 1..SAMPLE_W carry
  // the word MSB first and the remaining slots are zero padding.
  function automatic logic slot_bit(input sample_t word, input logic [SLOT_W-1:0] slot);
    logic [SLOT_W-1:0] idx;
    idx = SLOT_W'(SAMPLE_W) - slot;
    if (slot >= SLOT_W'(1) && slot <= SLOT_W'(SAMPLE_W)) begin
      return word[idx];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Purpose: bundle of the enable, sample strobe/data, I2S pins and status flags of i2s_dac_tx.
// Latency: n/a (wiring only).
// Backpressure: none; din_valid is a one-cycle strobe, the transmitter never stalls its source.
//
// Signals:
//   run                     enable, low holds the transmitter idle and clears its state
//   din_valid               one-cycle strobe qualifying l_data_in / r_data_in
//   l_data_in, r_data_in    34-bit signed interpolated samples
//   bclk, lrclk, sdata      I2S bit clock, word select (0 = left), serial data
//   underrun, overrun       sticky status flags
// Modports: master = sample source / status observer, slave = transmitter.
interface i2s_dac_tx_if;
  import audipus_pkg::*;

  logic            run;
  logic            din_valid;
  logic [IN_W-1:0] l_data_in;
  logic [IN_W-1:0] r_data_in;
  logic            bclk;
  logic            lrclk;
  logic            sdata;
  logic            underrun;
  logic            overrun;

  modport master (
    output run, din_valid, l_data_in, r_data_in,
    input  bclk, lrclk, sdata, underrun, overrun
  );

  modport slave (
    input  run, din_valid, l_data_in, r_data_in,
    output bclk, lrclk, sdata, underrun, overrun
  );

endinterface

// File: rtl/i2s_dac_tx_sat_shift.sv
// Purpose: arithmetic right shift of a 34-bit signed sample followed by saturation to 24 bits.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   x_i  34-bit signed interpolator sample
//   y_o  24-bit signed DAC word, clamped to [-8388608, 8388607]
module i2s_sat_shift
  import audipus_pkg::*;
#(
  parameter int SHIFT = 9
) (
  input  logic [IN_W-1:0] x_i,
  output sample_t         y_o
);

  logic signed [IN_W-1:0]        shifted;
  logic        [IN_W-SAMPLE_W:0] top_bits;

  assign shifted  = $signed(x_i) >>> SHIFT;
  // The shifted value fits in SAMPLE_W bits exactly when every bit from the target sign
  // position upward is a copy of the sign bit.
  assign top_bits = shifted[IN_W-1:SAMPLE_W-1];

  always_comb begin
    if (&top_bits || ~|top_bits) begin
      y_o = shifted[SAMPLE_W-1:0];
    end else if (shifted[IN_W-1]) begin
      y_o = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      y_o = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// Purpose: stereo I2S DAC transmitter with a one-deep pending buffer and frame-aligned word load.
// Latency: a sample strobed in frame N is loaded at the end of N; its left MSB appears at cnt 8 of N+1.
// Backpressure: none; a second strobe before the load overwrites (overrun), a load with nothing
//               pending repeats the previous words (underrun).
//
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  asynchronous active-high reset
//   bus    slave side of i2s_dac_tx_if (run, sample strobe/data in; I2S pins and flags out)
module i2s_dac_tx #(
  parameter int SHIFT     = 9,
  parameter int FRAME_LEN = 512
) (
  input  logic         clk,
  input  logic         reset,
  i2s_dac_tx_if.slave  bus
);
  import audipus_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  sample_t          pend_l_q, pend_l_d;
  sample_t          pend_r_q, pend_r_d;
  logic             pend_full_q, pend_full_d;
  sample_t          tx_l_q, tx_l_d;
  sample_t          tx_r_q, tx_r_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;

  sample_t          conv_l, conv_r;
  logic             load;
  logic [SLOT_W-1:0] slot_nxt;
  sample_t          word_nxt;

  i2s_sat_shift #(.SHIFT(SHIFT)) u_sat_l (
    .x_i (bus.l_data_in),
    .y_o (conv_l)
  );

  i2s_sat_shift #(.SHIFT(SHIFT)) u_sat_r (
    .x_i (bus.r_data_in),
    .y_o (conv_r)
  );

  always_comb begin
    cnt_d       = cnt_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    pend_full_d = pend_full_q;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    load        = 1'b0;
    slot_nxt    = '0;
    word_nxt    = '0;

    if (!bus.run) begin
      cnt_d       = '0;
      pend_l_d    = '0;
      pend_r_d    = '0;
      pend_full_d = 1'b0;
      tx_l_d      = '0;
      tx_r_d      = '0;
      bclk_d      = 1'b0;
      lrclk_d     = 1'b0;
      sdata_d     = 1'b0;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      load  = (cnt_q == LAST_CNT);
      cnt_d = load ? '0 : cnt_q + 1'b1;

      if (load) begin
        if (pend_full_q) begin
          tx_l_d      = pend_l_q;
          tx_r_d      = pend_r_q;
          pend_full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
        end
      end

      // A strobe coinciding with the load refills the buffer the load just emptied,
      // so it is not an overrun and the buffer stays full.
      if (bus.din_valid) begin
        pend_l_d    = conv_l;
        pend_r_d    = conv_r;
        pend_full_d = 1'b1;
        if (pend_full_q && !load) begin
          overrun_d = 1'b1;
        end
      end

      // Outputs are registered from the next count so that they line up with cnt_q.
      bclk_d  = cnt_d[PH_W-1];
      lrclk_d = cnt_d[CNT_W-1];

      // New serial bit only at the start of a bit period (bclk falling edge). At the
      // frame wrap the slot is 0, so using the freshly loaded words is safe.
      if (cnt_d[PH_W-1:0] == '0) begin
        slot_nxt = cnt_d[PH_W +: SLOT_W];
        word_nxt = cnt_d[CNT_W-1] ? tx_r_d : tx_l_d;
        sdata_d  = slot_bit(word_nxt, slot_nxt);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      pend_full_q <= 1'b0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_full_q <= pend_full_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.bclk     = bclk_q;
  assign bus.lrclk    = lrclk_q;
  assign bus.sdata    = sdata_q;
  assign bus.underrun = underrun_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Purpose: randomized scoreboard bench for i2s_dac_tx; frame-level reference model vs. deserialized I2S.
// Latency: expects words strobed in window F on the wire in frame F+1.
// Backpressure: n/a.
module tb_i2s_dac_tx;

  localparam int SHIFT = 9;
  localparam int FL    = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2s_dac_tx_if bus_if ();

  i2s_dac_tx #(.SHIFT(SHIFT), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct { int k; logic [33:0] l; logic [33:0] r; } strobe_t;
  typedef struct { logic [23:0] l; logic [23:0] r; bit und; bit ovr; } frame_exp_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  frame_exp_t exp_q[$];
  strobe_t    plan[$];
  int         cur_k    = 0;
  bit         running  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion: integer floor-shift then clamp to the signed 24-bit range.
  function automatic logic [23:0] ref_conv(input logic [33:0] x);
    longint v;
    v = longint'($signed(x));
    v = v >>> SHIFT;
    if (v > 64'sd8388607) v = 64'sd8388607;
    else if (v < -64'sd8388608) v = -64'sd8388608;
    return v[23:0];
  endfunction

  function automatic logic [33:0] rnd_sample();
    logic [33:0] v;
    longint      b;
    case ($urandom_range(0, 2))
      0: v = {2'($urandom_range(0, 3)), 32'($urandom)};
      1: v = 34'($signed(32'($urandom)));
      default: begin
        b = (64'sd1 <<< 32) - 512 + longint'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) b = -b;
        v = b[33:0];
      end
    endcase
    return v;
  endfunction

  task automatic add_strobe(input int k, input logic [33:0] l, input logic [33:0] r);
    plan.push_back('{k, l, r});
  endtask

  // Window f spans cycles k = FL*f-1 .. FL*f+FL-2 (cnt 511 of the previous frame up to cnt 510).
  task automatic fill_random(input int f);
    int n, chunk, off;
    n = $urandom_range(0, 3);
    if (n == 0) return;
    chunk = 510 / n;
    for (int i = 0; i < n; i++) begin
      off = i * chunk + $urandom_range(1, chunk);
      if (f > 0 && i == 0 && $urandom_range(0, 3) == 0) off = 0;
      add_strobe(FL * f - 1 + off, rnd_sample(), rnd_sample());
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_bclk"},     bus_if.bclk,     0);
    check({tag, "_lrclk"},    bus_if.lrclk,    0);
    check({tag, "_sdata"},    bus_if.sdata,    0);
    check({tag, "_underrun"}, bus_if.underrun, 0);
    check({tag, "_overrun"},  bus_if.overrun,  0);
  endtask

  // Runs nw stimulus windows plus one extra frame so the last window's words are seen.
  // abort_k >= 0 asserts reset in the middle of that cycle and leaves run high.
  task automatic run_segment(input int nw, input int abort_k);
    logic [23:0] prev_l, prev_r, last_l, last_r;
    bit          und, ovr;
    int          wcnt;
    strobe_t     s;
    prev_l = '0; prev_r = '0; last_l = '0; last_r = '0;
    und = 0; ovr = 0; wcnt = 0;
    exp_q.delete();
    exp_q.push_back('{24'h0, 24'h0, 1'b0, 1'b0});
    for (int k = 0; k < FL * (nw + 1); k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        reset      = 1'b0;
        bus_if.run = 1'b1;
      end
      cur_k   = k;
      running = 1'b1;
      bus_if.din_valid = 1'b0;
      if (plan.size() > 0 && plan[0].k == k) begin
        s = plan.pop_front();
        bus_if.din_valid = 1'b1;
        bus_if.l_data_in = s.l;
        bus_if.r_data_in = s.r;
        wcnt++;
        last_l = ref_conv(s.l);
        last_r = ref_conv(s.r);
      end
      if (k == abort_k) begin
        #2;
        reset   = 1'b1;
        running = 1'b0;
        bus_if.din_valid = 1'b0;
        exp_q.delete();
        plan.delete();
        #1;
        check_quiet("reset_midframe");
        return;
      end
      if (k % FL == FL - 2 && k / FL < nw) begin
        if (wcnt == 0) begin
          und = 1;
        end else begin
          prev_l = last_l;
          prev_r = last_r;
          if (wcnt > 1) ovr = 1;
        end
        exp_q.push_back('{prev_l, prev_r, und, ovr});
        wcnt = 0;
      end
    end
    @(posedge clk); #1;
    bus_if.run       = 1'b0;
    bus_if.din_valid = 1'b0;
    running          = 1'b0;
    @(posedge clk); #1;
    check_quiet("idle_after_run");
  endtask

  // Monitor: deserializes each frame from the pins and compares with the queued expectation.
  frame_exp_t  m_exp;
  bit          m_have = 0;
  bit          m_clk_err, m_stab_err, m_pad_err;
  logic [23:0] m_l, m_r;
  logic        m_prev = 1'b0;
  int          m_frame = 0;

  always @(negedge clk) begin
    int c, s;
    if (running) begin
      c = cur_k % FL;
      s = (c / 8) % 32;
      if (c == 0) begin
        m_frame = cur_k / FL;
        m_clk_err = 0; m_stab_err = 0; m_pad_err = 0;
        m_l = '0; m_r = '0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty frame %0d: got no expectation, expected one", m_frame);
          m_have = 0;
        end else begin
          m_exp  = exp_q.pop_front();
          m_have = 1;
          check($sformatf("underrun_f%0d", m_frame), bus_if.underrun, m_exp.und);
          check($sformatf("overrun_f%0d", m_frame),  bus_if.overrun,  m_exp.ovr);
        end
      end
      if (bus_if.bclk !== 1'((c >> 2) & 1) || bus_if.lrclk !== 1'((c >> 8) & 1)) m_clk_err = 1;
      if (c % 8 != 0 && bus_if.sdata !== m_prev) m_stab_err = 1;
      if (c % 8 == 4) begin
        if (s >= 1 && s <= 24) begin
          if (c < 256) m_l = {m_l[22:0], bus_if.sdata};
          else         m_r = {m_r[22:0], bus_if.sdata};
        end else if (bus_if.sdata !== 1'b0) begin
          m_pad_err = 1;
        end
      end
      m_prev = bus_if.sdata;
      if (c == FL - 1 && m_have) begin
        check($sformatf("clocks_f%0d", m_frame),    m_clk_err,  0);
        check($sformatf("sdata_phase_f%0d", m_frame), m_stab_err, 0);
        check($sformatf("padding_f%0d", m_frame),   m_pad_err,  0);
        check($sformatf("L_word_f%0d", m_frame),    m_l, m_exp.l);
        check($sformatf("R_word_f%0d", m_frame),    m_r, m_exp.r);
        m_have = 0;
      end
    end
  end

  initial begin
    reset            = 1'b1;
    bus_if.run       = 1'b0;
    bus_if.din_valid = 1'b0;
    bus_if.l_data_in = '0;
    bus_if.r_data_in = '0;
    #12;
    check_quiet("reset_state");

    // Released but not running: strobes must be ignored.
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    bus_if.din_valid = 1'b1;
    bus_if.l_data_in = 34'h0_1234_5600;
    bus_if.r_data_in = 34'h0_1234_5600;
    @(posedge clk); #1;
    bus_if.din_valid = 1'b0;
    @(posedge clk); #1;
    check_quiet("idle_ignore_strobe");

    // First frame empty, then unity words, then both saturation rails, then random.
    add_strobe(FL + 40, 34'h000000200, 34'h3FFFFFE00);
    add_strobe(2 * FL + 300, 34'h100000000, 34'h2FFFFFFFF);
    for (int f = 3; f < 6; f++) fill_random(f);
    run_segment(6, -1);

    // Repeat on missing strobe, then overwrite on double strobe.
    add_strobe(200, 34'h000000200, 34'h3FFFFFE00);
    add_strobe(2 * FL + 10, rnd_sample(), rnd_sample());
    add_strobe(2 * FL + 400, 34'h0_0ABC_DE00, 34'h3_FF12_3400);
    run_segment(3, -1);

    // Strobe exactly on the load cycle while the buffer is full.
    add_strobe(100, 34'h0_0001_0000, 34'h3_FFFF_0000);
    add_strobe(FL - 1, 34'h0_0040_0000, 34'h3_FFC0_0000);
    add_strobe(2 * FL + 250, rnd_sample(), rnd_sample());
    run_segment(3, -1);

    // Reset asserted at cnt 300 of frame 1 with run held high.
    add_strobe(50, rnd_sample(), rnd_sample());
    run_segment(3, FL + 300);
    repeat (20) @(posedge clk);
    #1;
    check_quiet("reset_hold");

    // Restart after reset release: first frame zeros, then random traffic.
    for (int f = 1; f < 4; f++) fill_random(f);
    run_segment(4, -1);

    for (int seg = 0; seg < 3; seg++) begin
      for (int f = 0; f < 5; f++) fill_random(f);
      run_segment(5, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
